// File: rtl/adc_lane_align_ctrl.sv
// rtl/adc_lane_align_ctrl.sv - ADC LVDS frame/data lane bitslip alignment sequencer
// Optional per-lane data-word training is built when ADC_ALIGN_DATA_TRAIN_EN is defined.
module adc_lane_align_ctrl #(
    parameter int                NLANES         = 8,
    parameter int                SER_W          = 8,
    parameter logic [SER_W-1:0]  FRAME_PATTERN  = 8'hF0,
    parameter logic [SER_W-1:0]  TRAIN_PATTERN  = 8'hA5,
    parameter int                SETTLE_CYCLES  = 4,
    parameter int                MATCH_CYCLES   = 16,
    parameter int                MISMATCH_LIMIT = 4,
    localparam int               SLIP_W         = $clog2(SER_W) + 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [SER_W-1:0]        frame_word,
    input  logic [NLANES*SER_W-1:0] data_words,
    output logic                    bitslip_frame,
    output logic [NLANES-1:0]       bitslip_data,
    output logic                    busy,
    output logic                    locked,
    output logic                    fail,
    output logic [SLIP_W-1:0]       slip_count,
    output logic [7:0]              relock_count,
    output logic [NLANES-1:0]       lane_ok
);
    localparam int MATCH_W  = $clog2(MATCH_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int MISS_W   = $clog2(MISMATCH_LIMIT + 1);

    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_CYCLES - 1);
    localparam logic [MATCH_W-1:0]  MATCH_INC   = 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INC  = 1;
    localparam logic [MISS_W-1:0]   MISS_LAST   = MISS_W'(MISMATCH_LIMIT - 1);
    localparam logic [MISS_W-1:0]   MISS_INC    = 1;
    localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(SER_W - 1);
    localparam logic [SLIP_W-1:0]   SLIP_INC    = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SLIP, S_SETTLE, S_CHECK, S_TRAIN, S_LOCKED, S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [SLIP_W-1:0]   slip_q, slip_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [7:0]          relock_q, relock_d;
    logic                bitslip_frame_q, slip_frame_d;
    logic [NLANES-1:0]   bitslip_data_q, slip_data_d;

`ifdef ADC_ALIGN_DATA_TRAIN_EN
    logic                             train_q, train_d;
    logic [NLANES-1:0]                lane_ok_q, lane_ok_d;
    logic [NLANES-1:0][MATCH_W-1:0]   lane_match_q, lane_match_d;
    logic [NLANES-1:0][SLIP_W-1:0]    lane_slip_q, lane_slip_d;
    logic [NLANES-1:0]                lane_miss;
    logic                             lane_over;
`endif

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        slip_d       = slip_q;
        settle_d     = settle_q;
        miss_d       = miss_q;
        relock_d     = relock_q;
        slip_frame_d = 1'b0;
        slip_data_d  = '0;
`ifdef ADC_ALIGN_DATA_TRAIN_EN
        train_d      = train_q;
        lane_ok_d    = lane_ok_q;
        lane_match_d = lane_match_q;
        lane_slip_d  = lane_slip_q;
        lane_miss    = '0;
        lane_over    = 1'b0;
`endif
        if (start && (state_q == S_IDLE || state_q == S_LOCKED || state_q == S_FAIL)) begin
            state_d = S_CHECK;
            match_d = '0;
            slip_d  = '0;
            miss_d  = '0;
`ifdef ADC_ALIGN_DATA_TRAIN_EN
            train_d      = 1'b0;
            lane_ok_d    = '0;
            lane_match_d = '0;
            lane_slip_d  = '0;
`endif
        end else begin
            case (state_q)
                S_CHECK: begin
                    if (frame_word == FRAME_PATTERN) begin
                        if (match_q == MATCH_LAST) begin
                            match_d = '0;
                            miss_d  = '0;
`ifdef ADC_ALIGN_DATA_TRAIN_EN
                            state_d      = S_TRAIN;
                            train_d      = 1'b1;
                            lane_ok_d    = '0;
                            lane_match_d = '0;
                            lane_slip_d  = '0;
`else
                            state_d = S_LOCKED;
`endif
                        end else begin
                            match_d = match_q + MATCH_INC;
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q == SLIP_LAST) begin
                            state_d = S_FAIL;
                        end else begin
                            // data lanes share the frame's bit offset, so slip them together
                            state_d      = S_SLIP;
                            slip_frame_d = 1'b1;
                            slip_data_d  = '1;
                        end
                    end
                end
                S_SLIP: begin
                    settle_d = '0;
                    state_d  = S_SETTLE;
`ifdef ADC_ALIGN_DATA_TRAIN_EN
                    if (train_q) begin
                        for (int i = 0; i < NLANES; i++) begin
                            if (bitslip_data_q[i]) lane_slip_d[i] = lane_slip_q[i] + SLIP_INC;
                        end
                    end else begin
                        slip_d = slip_q + SLIP_INC;
                    end
`else
                    slip_d = slip_q + SLIP_INC;
`endif
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
`ifdef ADC_ALIGN_DATA_TRAIN_EN
                        state_d = train_q ? S_TRAIN : S_CHECK;
`else
                        state_d = S_CHECK;
`endif
                    end else begin
                        settle_d = settle_q + SETTLE_INC;
                    end
                end
`ifdef ADC_ALIGN_DATA_TRAIN_EN
                S_TRAIN: begin
                    // lanes already passed are left alone so a late glitch cannot re-slip them
                    for (int i = 0; i < NLANES; i++) begin
                        if (data_words[i*SER_W +: SER_W] == TRAIN_PATTERN) begin
                            if (lane_match_q[i] == MATCH_LAST) lane_ok_d[i] = 1'b1;
                            else lane_match_d[i] = lane_match_q[i] + MATCH_INC;
                        end else begin
                            lane_match_d[i] = '0;
                            if (!lane_ok_q[i]) begin
                                lane_miss[i] = 1'b1;
                                if (lane_slip_q[i] == SLIP_LAST) lane_over = 1'b1;
                            end
                        end
                    end
                    if (lane_over) begin
                        state_d = S_FAIL;
                    end else if (lane_miss != '0) begin
                        state_d     = S_SLIP;
                        slip_data_d = lane_miss;
                    end else if (&lane_ok_d) begin
                        state_d = S_LOCKED;
                        miss_d  = '0;
                    end
                end
`endif
                S_LOCKED: begin
                    if (frame_word == FRAME_PATTERN) begin
                        miss_d = '0;
                    end else if (miss_q == MISS_LAST) begin
                        state_d  = S_CHECK;
                        miss_d   = '0;
                        match_d  = '0;
                        slip_d   = '0;
                        relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
`ifdef ADC_ALIGN_DATA_TRAIN_EN
                        train_d      = 1'b0;
                        lane_ok_d    = '0;
                        lane_match_d = '0;
                        lane_slip_d  = '0;
`endif
                    end else begin
                        miss_d = miss_q + MISS_INC;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= S_IDLE;
            match_q         <= '0;
            slip_q          <= '0;
            settle_q        <= '0;
            miss_q          <= '0;
            relock_q        <= '0;
            bitslip_frame_q <= 1'b0;
            bitslip_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            match_q         <= match_d;
            slip_q          <= slip_d;
            settle_q        <= settle_d;
            miss_q          <= miss_d;
            relock_q        <= relock_d;
            bitslip_frame_q <= slip_frame_d;
            bitslip_data_q  <= slip_data_d;
        end
    end

`ifdef ADC_ALIGN_DATA_TRAIN_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            train_q      <= 1'b0;
            lane_ok_q    <= '0;
            lane_match_q <= '0;
            lane_slip_q  <= '0;
        end else begin
            train_q      <= train_d;
            lane_ok_q    <= lane_ok_d;
            lane_match_q <= lane_match_d;
            lane_slip_q  <= lane_slip_d;
        end
    end

    assign lane_ok = lane_ok_q;
`else
    logic unused_train;
    assign unused_train = ^{data_words, TRAIN_PATTERN};
    assign lane_ok      = {NLANES{locked}};
`endif

    assign bitslip_frame = bitslip_frame_q;
    assign bitslip_data  = bitslip_data_q;
    assign busy          = (state_q == S_SLIP) || (state_q == S_SETTLE) ||
                           (state_q == S_CHECK) || (state_q == S_TRAIN);
    assign locked        = (state_q == S_LOCKED);
    assign fail          = (state_q == S_FAIL);
    assign slip_count    = slip_q;
    assign relock_count  = relock_q;

endmodule

// File: tb/tb_adc_lane_align_ctrl.sv
// tb/tb_adc_lane_align_ctrl.sv - randomized directed bench for adc_lane_align_ctrl (default build)
module tb_adc_lane_align_ctrl;
    localparam logic [7:0] FP    = 8'hF0;
    localparam int         MATCH = 16;
    localparam int         ROUND = 6;   // mismatch check + slip + 4 settle cycles

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  frame_word = 8'h00;
    logic [63:0] data_words = '0;
    logic        bitslip_frame;
    logic [7:0]  bitslip_data;
    logic        busy, locked, fail;
    logic [3:0]  slip_count;
    logic [7:0]  relock_count;
    logic [7:0]  lane_ok;

    adc_lane_align_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .frame_word(frame_word), .data_words(data_words),
        .bitslip_frame(bitslip_frame), .bitslip_data(bitslip_data),
        .busy(busy), .locked(locked), .fail(fail),
        .slip_count(slip_count), .relock_count(relock_count), .lane_ok(lane_ok)
    );

    always #5 aclk = ~aclk;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int offset = 0;        // bit rotation the deserializer still has to slip out
    int mode = 0;          // 0 aligned-by-offset, 1 stuck zero, 2 corrupted words
    int cyc = 0, last_pulse = -100, n_pulses = 0;
    int exp_relock = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        return (w << n) | (w >> (8 - n));
    endfunction

    function automatic logic [7:0] bad_word();
        logic [7:0] w;
        do w = 8'($urandom); while (w == FP);
        return w;
    endfunction

    task automatic drive();
        data_words = {$urandom, $urandom};
        case (mode)
            0:       frame_word = rotl(FP, offset);
            1:       frame_word = 8'h00;
            default: frame_word = bad_word();
        endcase
    endtask

    task automatic tick();
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
        if (bitslip_frame || bitslip_data != 8'h00) begin
            chk("slip_mirror", bitslip_data, bitslip_frame ? 8'hFF : 8'h00);
            if (bitslip_frame) begin
                chk("slip_gap", (cyc - last_pulse) >= 5, 1);
                last_pulse = cyc;
                n_pulses++;
                offset = (offset + 7) % 8;
            end
        end
        drive();
    endtask

    // expected lock: k slip rounds then MATCH consecutive good words
    task automatic align_run(input int k);
        int t_lock;
        t_lock = ROUND * k + MATCH;
        offset = k; mode = 0; n_pulses = 0;
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_state", {busy, locked, fail}, 3'b100);
        for (int c = 1; c <= t_lock; c++) begin
            start = (c == 3);
            tick();
            if (c == t_lock - 1) chk("pre_lock", {busy, locked}, 2'b10);
        end
        start = 1'b0;
        chk("lock_state", {busy, locked, fail}, 3'b010);
        chk("slip_pulses", n_pulses, k);
        chk("slip_count", slip_count, k);
        chk("lane_ok", lane_ok, 8'hFF);
        chk("relock_hold", relock_count, exp_relock);
    endtask

    task automatic inject(input int n);
        mode = 2;
        drive();
        for (int i = 1; i <= n; i++) begin
            if (i == n) mode = 0;
            tick();
        end
    endtask

    initial begin
        drive();
        repeat (3) tick();
        chk("reset_out", {bitslip_frame, bitslip_data, busy, locked, fail, slip_count, relock_count, lane_ok}, 0);
        aresetn = 1'b1;
        repeat (4) tick();
        chk("idle_no_start", {busy, locked, fail, n_pulses[7:0]}, 0);

        align_run(0);
        align_run(3);
        repeat (3) align_run($urandom_range(1, 7));

        begin
            int n;
            n = $urandom_range(1, 3);
            inject(n);
            repeat (2) tick();
            chk("short_burst_locked", locked, 1);
            inject(3);
            tick();
            inject(3);
            repeat (2) tick();
            chk("burst_reset_by_match", {locked, relock_count}, {1'b1, 8'(exp_relock)});
        end

        inject(3);
        chk("third_bad_locked", locked, 1);
        inject(1);
        exp_relock++;
        chk("loss_unlocked", {busy, locked}, 2'b10);
        chk("loss_relock_cnt", relock_count, exp_relock);
        chk("loss_slip_clr", slip_count, 0);
        for (int c = 5; c <= 4 + MATCH; c++) begin
            tick();
            if (c == 3 + MATCH) chk("relock_pre", locked, 0);
        end
        chk("relocked", locked, 1);

        mode = 1; n_pulses = 0;
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ROUND * 7 + 1; c++) begin
            tick();
            if (c == ROUND * 7) chk("pre_fail", {busy, fail}, 2'b10);
        end
        chk("fail_state", {busy, locked, fail}, 3'b001);
        chk("fail_slips", n_pulses, 7);
        chk("fail_slip_count", slip_count, 7);
        repeat (5) tick();
        chk("fail_sticky", {fail, n_pulses[7:0]}, {1'b1, 8'd7});
        align_run($urandom_range(0, 7));

        for (int l = 0; l < 257; l++) begin
            inject(4);
            exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
            repeat (MATCH) tick();
        end
        chk("relock_saturate", {locked, relock_count}, {1'b1, 8'(exp_relock)});
        chk("relock_sat_val", relock_count, 255);

        offset = 3; mode = 0;
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("in_settle", {busy, locked, slip_count}, {1'b1, 1'b0, 4'd1});
        #2 aresetn = 1'b0;
        #1;
        chk("arst_async", {bitslip_frame, bitslip_data, busy, locked, fail, slip_count, relock_count, lane_ok}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_relock = 0;
        n_pulses = 0;
        repeat (20) tick();
        chk("post_reset_idle", {busy, locked, fail, n_pulses[7:0]}, 0);
        align_run($urandom_range(1, 7));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
